// File: rtl/mem_arb_if.sv
// Bus bundle between the memory arbiter, its CPU and video clients, and the RAM.
// master: client/RAM side (drives requests and mem_din); slave: arbiter side.
interface mem_arb_if;
    logic        cpu_en;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        cpu_ben;
    logic [19:0] cpu_adr;
    logic [31:0] cpu_din;
    logic [31:0] cpu_dout;
    logic        cpu_wait;

    logic        vid_req;
    logic [17:0] vid_adr;
    logic [31:0] vid_data;
    logic        vid_valid;
    logic        vid_done;

    logic [17:0] mem_adr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;

    modport master (
        output cpu_en, cpu_rd, cpu_wr, cpu_ben, cpu_adr, cpu_din,
        output vid_req, vid_adr,
        output mem_din,
        input  cpu_dout, cpu_wait,
        input  vid_data, vid_valid, vid_done,
        input  mem_adr, mem_we, mem_be, mem_dout
    );

    modport slave (
        input  cpu_en, cpu_rd, cpu_wr, cpu_ben, cpu_adr, cpu_din,
        input  vid_req, vid_adr,
        input  mem_din,
        output cpu_dout, cpu_wait,
        output vid_data, vid_valid, vid_done,
        output mem_adr, mem_we, mem_be, mem_dout
    );
endinterface

// File: rtl/mem_arb.sv
// Single-port RAM arbiter: CPU word/byte accesses vs. fixed-length video bursts.
// Ports: clk, rst_n (async, active-low), bus (mem_arb_if.slave: cpu_*, vid_*, mem_*).
module mem_arb #(
    parameter int BURST = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_arb_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CRD1, CRD2, CWR, VID, VTAIL} state_t;

    localparam logic [5:0] LAST = 6'(BURST - 1);

    state_t      state;
    logic        cpu_turn;
    logic        ben_q;
    logic [1:0]  lane_q;
    logic [5:0]  cnt;
    logic [17:0] mem_adr_q;
    logic        mem_we_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_dout_q;
    logic [31:0] cpu_dout_q;
    logic        vid_valid_q;
    logic        vid_done_q;

    logic        cpu_req;
    logic        ack;
    logic        grant_vid;
    logic        grant_cpu;
    logic [3:0]  be_now;
    logic [31:0] wr_data;
    logic [7:0]  rd_byte;
    logic [31:0] rd_data;

    assign cpu_req = bus.cpu_en & (bus.cpu_rd | bus.cpu_wr);
    assign ack     = (state == CWR) || (state == CRD2);

    // cpu_turn is set after a video grant (and out of reset), so the CPU
    // wins a tie then; otherwise video wins the tie.
    assign grant_vid = bus.vid_req & (~cpu_req | ~cpu_turn);
    assign grant_cpu = cpu_req & ~grant_vid;

    assign be_now  = bus.cpu_ben ? (4'b0001 << bus.cpu_adr[1:0]) : 4'b1111;
    assign wr_data = bus.cpu_ben ? {4{bus.cpu_din[7:0]}} : bus.cpu_din;

    always_comb begin
        rd_byte = bus.mem_din[7:0];
        case (lane_q)
            2'd0:    rd_byte = bus.mem_din[7:0];
            2'd1:    rd_byte = bus.mem_din[15:8];
            2'd2:    rd_byte = bus.mem_din[23:16];
            default: rd_byte = bus.mem_din[31:24];
        endcase
    end

    assign rd_data = ben_q ? {24'h0, rd_byte} : bus.mem_din;

    assign bus.cpu_wait  = cpu_req & ~ack;
    // Read data comes straight from the RAM during the ack cycle and is
    // held afterwards so the CPU can sample it as soon as cpu_wait drops.
    assign bus.cpu_dout  = (state == CRD2) ? rd_data : cpu_dout_q;
    assign bus.mem_adr   = mem_adr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_dout  = mem_dout_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.vid_done  = vid_done_q;
    assign bus.vid_data  = vid_valid_q ? bus.mem_din : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cpu_turn    <= 1'b1;
            ben_q       <= 1'b0;
            lane_q      <= 2'd0;
            cnt         <= 6'd0;
            mem_adr_q   <= 18'h0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_dout_q  <= 32'h0;
            cpu_dout_q  <= 32'h0;
            vid_valid_q <= 1'b0;
            vid_done_q  <= 1'b0;
        end else begin
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            vid_valid_q <= 1'b0;
            vid_done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vid) begin
                        state     <= VID;
                        cpu_turn  <= 1'b1;
                        cnt       <= 6'd0;
                        mem_adr_q <= bus.vid_adr;
                        mem_be_q  <= 4'hF;
                    end else if (grant_cpu) begin
                        cpu_turn  <= 1'b0;
                        ben_q     <= bus.cpu_ben;
                        lane_q    <= bus.cpu_adr[1:0];
                        mem_adr_q <= bus.cpu_adr[19:2];
                        mem_be_q  <= be_now;
                        if (bus.cpu_wr) begin
                            state      <= CWR;
                            mem_we_q   <= 1'b1;
                            mem_dout_q <= wr_data;
                        end else begin
                            state <= CRD1;
                        end
                    end
                end
                CRD1: state <= CRD2;
                CRD2: begin
                    cpu_dout_q <= rd_data;
                    state      <= IDLE;
                end
                CWR: state <= IDLE;
                VID: begin
                    vid_valid_q <= 1'b1;
                    if (cnt == LAST) begin
                        state      <= VTAIL;
                        vid_done_q <= 1'b1;
                    end else begin
                        cnt       <= cnt + 6'd1;
                        mem_adr_q <= mem_adr_q + 18'd1;
                        mem_be_q  <= 4'hF;
                    end
                end
                VTAIL: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb with a behavioural RAM model.
// Scenarios: reset, word/byte access, bursts, arbitration, contention, mid-burst reset.
module tb_mem_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arb_if bus ();

    mem_arb #(.BURST(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0]  ram [0:255];
    logic [255:0] wr_mask = '0;

    function automatic logic [31:0] pat(input logic [17:0] a);
        return 32'hC0DE0000 ^ {14'h0, a};
    endfunction

    function automatic logic [31:0] ram_rd(input logic [17:0] a);
        if (a[17:8] == 10'h0 && wr_mask[a[7:0]]) return ram[a[7:0]];
        return pat(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_we) begin
            ram[bus.mem_adr[7:0]]     <= merge(ram_rd(bus.mem_adr), bus.mem_dout, bus.mem_be);
            wr_mask[bus.mem_adr[7:0]] <= 1'b1;
        end
        bus.mem_din <= ram_rd(bus.mem_adr);
    end

    task automatic idle_inputs;
        bus.cpu_en  = 1'b0;
        bus.cpu_rd  = 1'b0;
        bus.cpu_wr  = 1'b0;
        bus.cpu_ben = 1'b0;
        bus.cpu_adr = 20'h0;
        bus.cpu_din = 32'h0;
        bus.vid_req = 1'b0;
        bus.vid_adr = 18'h0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cpu_access(input logic wr, input logic ben,
                              input logic [19:0] adr, input logic [31:0] din,
                              output int waits, output logic [31:0] rdata,
                              output logic [17:0] madr, output logic [3:0] mbe,
                              output logic mwe, output logic [31:0] mdout);
        @(negedge clk);
        bus.cpu_en  = 1'b1;
        bus.cpu_rd  = ~wr;
        bus.cpu_wr  = wr;
        bus.cpu_ben = ben;
        bus.cpu_adr = adr;
        bus.cpu_din = din;
        waits = 0;
        #1;
        while (bus.cpu_wait && waits < 40) begin
            waits++;
            @(negedge clk);
            #1;
        end
        rdata = bus.cpu_dout;
        madr  = bus.mem_adr;
        mbe   = bus.mem_be;
        mwe   = bus.mem_we;
        mdout = bus.mem_dout;
        @(negedge clk);
        bus.cpu_en = 1'b0;
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.cpu_wait !== 1'b0 || bus.cpu_dout !== 32'h0) begin
            failures++;
            $display("FAIL reset_cpu wait=%b dout=%h want 0/0", bus.cpu_wait, bus.cpu_dout);
        end
        checks++;
        if (bus.mem_adr !== 18'h0 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0 || bus.mem_dout !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem adr=%h we=%b be=%b dout=%h want zeros",
                     bus.mem_adr, bus.mem_we, bus.mem_be, bus.mem_dout);
        end
        checks++;
        if (bus.vid_valid !== 1'b0 || bus.vid_done !== 1'b0 || bus.vid_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_vid valid=%b done=%b data=%h want zeros",
                     bus.vid_valid, bus.vid_done, bus.vid_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_write;
        int waits;
        logic [31:0] rd, md;
        logic [17:0] ma;
        logic [3:0] be;
        logic we;
        cpu_access(1'b1, 1'b0, 20'h00104, 32'hDEADBEEF, waits, rd, ma, be, we, md);
        checks++;
        if (waits !== 1) begin
            failures++;
            $display("FAIL wwr_waits got %0d want 1", waits);
        end
        checks++;
        if (ma !== 18'h00041 || be !== 4'b1111 || we !== 1'b1 || md !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wwr_bus adr=%h be=%b we=%b dout=%h want 00041/1111/1/deadbeef", ma, be, we, md);
        end
        #1;
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0 || bus.mem_adr !== 18'h00041 || bus.mem_dout !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wwr_after we=%b be=%b adr=%h dout=%h want 0/0000/00041/deadbeef",
                     bus.mem_we, bus.mem_be, bus.mem_adr, bus.mem_dout);
        end
    endtask

    task automatic test_byte_access;
        int waits;
        logic [31:0] rd, md;
        logic [17:0] ma;
        logic [3:0] be;
        logic we;
        cpu_access(1'b1, 1'b1, 20'h00107, 32'h000000A5, waits, rd, ma, be, we, md);
        checks++;
        if (waits !== 1 || ma !== 18'h00041 || be !== 4'b1000 || we !== 1'b1 || md !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL bwr_lane3 waits=%0d adr=%h be=%b we=%b dout=%h want 1/00041/1000/1/a5a5a5a5",
                     waits, ma, be, we, md);
        end
        cpu_access(1'b1, 1'b1, 20'h00100, 32'h12345677, waits, rd, ma, be, we, md);
        checks++;
        if (be !== 4'b0001 || md !== 32'h77777777 || ma !== 18'h00040) begin
            failures++;
            $display("FAIL bwr_lane0 adr=%h be=%b dout=%h want 00040/0001/77777777", ma, be, md);
        end
        cpu_access(1'b0, 1'b1, 20'h00107, 32'h0, waits, rd, ma, be, we, md);
        checks++;
        if (waits !== 2 || rd !== 32'h000000A5) begin
            failures++;
            $display("FAIL brd_lane3 waits=%0d data=%h want 2/000000a5", waits, rd);
        end
        cpu_access(1'b0, 1'b0, 20'h00104, 32'h0, waits, rd, ma, be, we, md);
        checks++;
        if (waits !== 2 || rd !== 32'hA5ADBEEF) begin
            failures++;
            $display("FAIL wrd waits=%0d data=%h want 2/a5adbeef", waits, rd);
        end
        cpu_access(1'b0, 1'b1, 20'h00105, 32'h0, waits, rd, ma, be, we, md);
        checks++;
        if (waits !== 2 || rd !== 32'h000000BE) begin
            failures++;
            $display("FAIL brd_lane1 waits=%0d data=%h want 2/000000be", waits, rd);
        end
        #1;
        checks++;
        if (bus.cpu_dout !== 32'h000000BE) begin
            failures++;
            $display("FAIL rd_hold dout=%h want 000000be", bus.cpu_dout);
        end
    endtask

    task automatic test_burst(input logic [17:0] adr);
        logic [17:0] aq[$];
        logic [31:0] dq[$];
        logic [17:0] a;
        int nval = 0;
        int ndone = 0;
        @(negedge clk);
        bus.vid_adr = adr;
        bus.vid_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = adr + 18'(i);
            aq.push_back(a);
            dq.push_back(pat(a));
        end
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            bus.vid_req = 1'b0;
            #1;
            if (bus.mem_be !== 4'h0) begin
                checks++;
                if (aq.size() == 0) begin
                    failures++;
                    $display("FAIL burst_extra_issue adr=%h be=%b want none", bus.mem_adr, bus.mem_be);
                end else begin
                    a = aq.pop_front();
                    if (bus.mem_adr !== a || bus.mem_be !== 4'hF || bus.mem_we !== 1'b0) begin
                        failures++;
                        $display("FAIL burst_adr adr=%h be=%b we=%b want %h/1111/0",
                                 bus.mem_adr, bus.mem_be, bus.mem_we, a);
                    end
                end
            end
            if (bus.vid_valid === 1'b1) begin
                nval++;
                checks++;
                if (dq.size() == 0) begin
                    failures++;
                    $display("FAIL burst_extra_valid data=%h want none", bus.vid_data);
                end else begin
                    logic [31:0] d;
                    d = dq.pop_front();
                    if (bus.vid_data !== d) begin
                        failures++;
                        $display("FAIL burst_data got %h want %h", bus.vid_data, d);
                    end
                end
            end
            if (bus.vid_done === 1'b1) begin
                ndone++;
                checks++;
                if (nval !== 8 || bus.vid_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL burst_done_pos at valid #%0d valid=%b want #8/1", nval, bus.vid_valid);
                end
            end
        end
        checks++;
        if (nval !== 8 || ndone !== 1 || aq.size() != 0) begin
            failures++;
            $display("FAIL burst_count valids=%0d dones=%0d left=%0d want 8/1/0", nval, ndone, aq.size());
        end
    endtask

    task automatic test_arbitration;
        logic [7:0] eq[$];
        logic [7:0] e;
        bit first_c = 1'b1;
        do_reset();
        @(negedge clk);
        eq.push_back("C");
        eq.push_back("V");
        eq.push_back("C");
        eq.push_back("V");
        bus.cpu_en  = 1'b1;
        bus.cpu_rd  = 1'b1;
        bus.cpu_ben = 1'b0;
        bus.cpu_adr = 20'h00104;
        bus.vid_adr = 18'h00020;
        bus.vid_req = 1'b1;
        #1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (eq.size() != 0 && (bus.cpu_wait === 1'b0 || bus.vid_done === 1'b1)) begin
                e = eq.pop_front();
                checks++;
                if ((e == "C") !== (bus.cpu_wait === 1'b0)) begin
                    failures++;
                    $display("FAIL arb_order got %s want %c", bus.vid_done ? "V" : "C", e);
                end
                if (first_c && bus.cpu_wait === 1'b0) begin
                    first_c = 1'b0;
                    checks++;
                    if (bus.cpu_dout !== 32'hA5ADBEEF || cyc !== 2) begin
                        failures++;
                        $display("FAIL arb_cpu_first data=%h cycle=%0d want a5adbeef/2", bus.cpu_dout, cyc);
                    end
                end
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (eq.size() != 0) begin
            failures++;
            $display("FAIL arb_events missing=%0d want 0", eq.size());
        end
        idle_inputs();
        repeat (15) @(negedge clk);
    endtask

    task automatic test_cpu_during_burst;
        int done_c = -10;
        int we_c = -10;
        int wait_cnt = 0;
        bit early = 1'b0;
        logic [17:0] ma = '0;
        logic [3:0] be = '0;
        logic [31:0] md = '0;
        @(negedge clk);
        bus.vid_adr = 18'h00040;
        bus.vid_req = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 1) bus.vid_req = 1'b0;
            if (c == 3) begin
                bus.cpu_en  = 1'b1;
                bus.cpu_wr  = 1'b1;
                bus.cpu_ben = 1'b0;
                bus.cpu_adr = 20'h00208;
                bus.cpu_din = 32'h12345678;
            end
            if (c == we_c + 1) begin
                bus.cpu_en = 1'b0;
                bus.cpu_wr = 1'b0;
            end
            #1;
            if (bus.vid_done === 1'b1) done_c = c;
            if (bus.mem_we === 1'b1) begin
                we_c = c;
                ma = bus.mem_adr;
                be = bus.mem_be;
                md = bus.mem_dout;
            end
            if (bus.cpu_en && bus.cpu_wr) begin
                if (bus.cpu_wait === 1'b1) wait_cnt++;
                else if (bus.mem_we !== 1'b1) early = 1'b1;
            end
        end
        checks++;
        if (done_c !== 9 || we_c !== 11) begin
            failures++;
            $display("FAIL contend_timing done_cycle=%0d we_cycle=%0d want 9/11", done_c, we_c);
        end
        checks++;
        if (wait_cnt !== 8 || early !== 1'b0) begin
            failures++;
            $display("FAIL contend_wait waits=%0d early_ack=%b want 8/0", wait_cnt, early);
        end
        checks++;
        if (ma !== 18'h00082 || be !== 4'hF || md !== 32'h12345678) begin
            failures++;
            $display("FAIL contend_write adr=%h be=%b dout=%h want 00082/1111/12345678", ma, be, md);
        end
    endtask

    task automatic test_reset_mid_burst;
        int nval = 0;
        int late = 0;
        bit hit = 1'b0;
        @(negedge clk);
        bus.vid_adr = 18'h00300;
        bus.vid_req = 1'b1;
        for (int c = 0; c < 30 && !hit; c++) begin
            @(negedge clk);
            bus.vid_req = 1'b0;
            #1;
            if (bus.vid_valid === 1'b1) nval++;
            if (nval == 5) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL midrst_reach valids=%0d want 5", nval);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.vid_valid !== 1'b0 || bus.vid_done !== 1'b0 || bus.vid_data !== 32'h0 ||
            bus.mem_adr !== 18'h0 || bus.mem_be !== 4'h0 || bus.mem_we !== 1'b0 ||
            bus.mem_dout !== 32'h0 || bus.cpu_dout !== 32'h0) begin
            failures++;
            $display("FAIL midrst_outputs valid=%b done=%b data=%h adr=%h be=%b we=%b dout=%h cdout=%h want zeros",
                     bus.vid_valid, bus.vid_done, bus.vid_data, bus.mem_adr, bus.mem_be,
                     bus.mem_we, bus.mem_dout, bus.cpu_dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.vid_adr = 18'h00010;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            #1;
            if (bus.vid_valid === 1'b1 || bus.vid_done === 1'b1 || bus.mem_be !== 4'h0) late++;
        end
        checks++;
        if (late !== 0) begin
            failures++;
            $display("FAIL midrst_quiet active_cycles=%0d want 0", late);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_word_write();
        test_byte_access();
        test_burst(18'h3FFFC);
        test_arbitration();
        test_cpu_during_burst();
        test_reset_mid_burst();
        test_burst(18'h00010);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
